// File: rtl/mux_chan_sched.sv
// Two-channel 4-bit selector: debounced button or auto-scan picks the
// channel shown on led, with a one-cycle blank slot at every changeover.
module mux_chan_sched #(
  parameter int DEB_CYCLES  = 4,
  parameter int SCAN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       pba,
  input  logic       auto,
  output logic [3:0] led,
  output logic       sel,
  output logic       chg
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t state;
  state_t nxt;

  logic          sync1;
  logic          pba_s;
  logic          deb;
  logic          deb_q;
  logic [DW-1:0] deb_cnt;
  logic [SW-1:0] scan_cnt;

  logic          press;
  logic          tick;
  logic          req;
  logic [3:0]    led_nxt;
  logic          sel_nxt;
  logic          chg_nxt;

  // Button: 2-FF synchronizer, then accept a level only after it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      pba_s   <= 1'b0;
      deb     <= 1'b0;
      deb_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= pba;
      pba_s <= sync1;
      deb_q <= deb;
      if (pba_s != deb) begin
        if (deb_cnt == DEB_LAST) begin
          deb     <= pba_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press = deb & ~deb_q;
  assign tick  = (scan_cnt == SCAN_LAST);
  assign req   = auto ? tick : press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (!auto || nxt == BLANK) begin
      scan_cnt <= '0;
    end else if (state != BLANK) begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEL_A;
      led   <= 4'h0;
      sel   <= 1'b0;
      chg   <= 1'b0;
    end else begin
      state <= nxt;
      led   <= led_nxt;
      sel   <= sel_nxt;
      chg   <= chg_nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      SEL_A:   if (req) nxt = BLANK;
      SEL_B:   if (req) nxt = BLANK;
      BLANK:   nxt = sel ? SEL_B : SEL_A;
      default: nxt = SEL_A;
    endcase
  end

  // sel flips as BLANK is entered, so it names the pending channel.
  always_comb begin
    led_nxt = 4'h0;
    sel_nxt = sel;
    chg_nxt = (state == BLANK);
    case (nxt)
      SEL_A:   led_nxt = sw[3:0];
      SEL_B:   led_nxt = sw[7:4];
      default: led_nxt = 4'h0;
    endcase
    case (state)
      SEL_A:   sel_nxt = req;
      SEL_B:   sel_nxt = ~req;
      default: sel_nxt = sel;
    endcase
  end

endmodule

// File: tb/tb_mux_chan_sched.sv
// Directed checks for mux_chan_sched: reset, manual toggle, bounce,
// auto scan, reset during blank, and button ignored in auto mode.
module tb_mux_chan_sched;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       pba;
  logic       auto;
  logic [3:0] led;
  logic       sel;
  logic       chg;

  int pass_cnt = 0;
  int total    = 0;

  mux_chan_sched #(
    .DEB_CYCLES (4),
    .SCAN_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .pba (pba),
    .auto(auto),
    .led (led),
    .sel (sel),
    .chg (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pba = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Auto schedule, n = edges since reset release, sw = 8'h3C.
  function automatic logic [3:0] sch_led(int n);
    int m, k;
    if (n < 16) return 4'hC;
    m = (n - 16) % 17;
    k = (n - 16) / 17;
    if (m == 0) return 4'h0;
    return (k % 2 == 0) ? 4'h3 : 4'hC;
  endfunction

  function automatic logic sch_sel(int n);
    if (n < 16) return 1'b0;
    return (((n - 16) / 17) % 2 == 0);
  endfunction

  function automatic logic sch_chg(int n);
    if (n < 16) return 1'b0;
    return ((n - 16) % 17 == 1);
  endfunction

  task automatic test_reset();
    sw   = 8'hA5;
    auto = 1'b0;
    rst  = 1'b1;
    pba  = 1'b0;
    step();
    total++;
    if ({led, sel, chg} !== 6'b0) begin
      $display("FAIL reset_state led=%h sel=%b chg=%b want 0/0/0",
               led, sel, chg);
    end else pass_cnt++;
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      total++;
      if (chg !== 1'b0 || sel !== 1'b0 || led !== 4'h5) begin
        $display("FAIL reset_first n=%0d led=%h sel=%b chg=%b want 5/0/0",
                 n, led, sel, chg);
      end else pass_cnt++;
    end
  endtask

  task automatic test_manual_toggle();
    logic [3:0] el;
    logic       es, ec;
    int         blanks = 0;
    sw   = 8'hA5;
    auto = 1'b0;
    do_reset();
    step();
    step();
    pba = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n < 7)       begin el = 4'h5; es = 1'b0; ec = 1'b0; end
      else if (n == 7) begin el = 4'h0; es = 1'b1; ec = 1'b0; end
      else if (n == 8) begin el = 4'hA; es = 1'b1; ec = 1'b1; end
      else             begin el = 4'hA; es = 1'b1; ec = 1'b0; end
      if (led == 4'h0) blanks++;
      total++;
      if (led !== el || sel !== es || chg !== ec) begin
        $display("FAIL toggle n=%0d led=%h sel=%b chg=%b want %h/%b/%b",
                 n, led, sel, chg, el, es, ec);
      end else pass_cnt++;
    end
    total++;
    if (blanks !== 1) begin
      $display("FAIL toggle_blanks got %0d want 1", blanks);
    end else pass_cnt++;
    pba = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      total++;
      if (led !== 4'hA || sel !== 1'b1 || chg !== 1'b0) begin
        $display("FAIL release n=%0d led=%h sel=%b chg=%b want A/1/0",
                 n, led, sel, chg);
      end else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    sw   = 8'hA5;
    auto = 1'b0;
    do_reset();
    step();
    for (int n = 0; n < 30; n++) begin
      pba = (n < 20) ? ~n[1] : 1'b0;
      step();
      total++;
      if (led !== 4'h5 || sel !== 1'b0 || chg !== 1'b0) begin
        $display("FAIL bounce n=%0d led=%h sel=%b chg=%b want 5/0/0",
                 n, led, sel, chg);
      end else pass_cnt++;
    end
  endtask

  task automatic test_auto_scan();
    sw   = 8'h3C;
    auto = 1'b1;
    do_reset();
    for (int n = 1; n <= 52; n++) begin
      step();
      total++;
      if (led !== sch_led(n) || sel !== sch_sel(n) || chg !== sch_chg(n)) begin
        $display("FAIL auto n=%0d led=%h sel=%b chg=%b want %h/%b/%b",
                 n, led, sel, chg, sch_led(n), sch_sel(n), sch_chg(n));
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_in_blank();
    sw   = 8'hA5;
    auto = 1'b0;
    do_reset();
    pba = 1'b1;
    repeat (7) step();
    total++;
    if (led !== 4'h0 || sel !== 1'b1) begin
      $display("FAIL rb_blank led=%h sel=%b want 0/1", led, sel);
    end else pass_cnt++;
    rst = 1'b1;
    pba = 1'b0;
    #1;
    total++;
    if (led !== 4'h0 || sel !== 1'b0 || chg !== 1'b0) begin
      $display("FAIL rb_async led=%h sel=%b chg=%b want 0/0/0",
               led, sel, chg);
    end else pass_cnt++;
    step();
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      total++;
      if (led !== 4'h5 || sel !== 1'b0 || chg !== 1'b0) begin
        $display("FAIL rb_after n=%0d led=%h sel=%b chg=%b want 5/0/0",
                 n, led, sel, chg);
      end else pass_cnt++;
    end
  endtask

  task automatic test_auto_press();
    sw   = 8'h3C;
    auto = 1'b1;
    do_reset();
    for (int n = 1; n <= 45; n++) begin
      pba = (n >= 3 && n < 13);
      step();
      total++;
      if (led !== sch_led(n) || sel !== sch_sel(n) || chg !== sch_chg(n)) begin
        $display("FAIL auto_press n=%0d led=%h sel=%b chg=%b want %h/%b/%b",
                 n, led, sel, chg, sch_led(n), sch_sel(n), sch_chg(n));
      end else pass_cnt++;
    end
  endtask

  initial begin
    rst  = 1'b1;
    sw   = 8'h00;
    pba  = 1'b0;
    auto = 1'b0;
    test_reset();
    test_manual_toggle();
    test_bounce();
    test_auto_scan();
    test_reset_in_blank();
    test_auto_press();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
